// File: rtl/pad_poller.sv
// Autonomous two-pad SNES-style serial scanner: latches both pads, clocks out
// PAD_BITS per pad and publishes active-high button words atomically.
module pad_poller #(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned PAD_BITS    = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic        pad_latch,
  output logic        pad_clk,
  input  logic [1:0]  pad_data,
  output logic [15:0] pad_state_p1,
  output logic [15:0] pad_state_p2,
  output logic        busy,
  output logic        done
);

  if (HALF_PERIOD < 4 || HALF_PERIOD > 255) begin : g_bad_half_period
    $error("pad_poller: HALF_PERIOD must be in 4..255");
  end
  if (PAD_BITS < 1 || PAD_BITS > 16) begin : g_bad_pad_bits
    $error("pad_poller: PAD_BITS must be in 1..16");
  end

  localparam int unsigned           IDX_W      = $clog2(PAD_BITS) + 1;
  localparam logic [7:0]            CNT_RELOAD = 8'(HALF_PERIOD - 1);
  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(PAD_BITS - 1);

  typedef enum logic [2:0] {IDLE, LATCH, HIGH, LOW, COMMIT} state_t;

  state_t           state, state_next;
  logic [1:0]       data_meta, data_sync;
  logic [7:0]       cnt;
  logic             second_half;
  logic [IDX_W-1:0] idx;
  logic [15:0]      shift_p1, shift_p2;
  logic [15:0]      bit_mask;
  logic             cnt_zero;
  logic             load_cnt, set_half, clr_scan, capture, idx_inc, commit;

  assign cnt_zero = (cnt == '0);
  assign bit_mask = 16'(1) << idx;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_cnt   = 1'b0;
    set_half   = 1'b0;
    clr_scan   = 1'b0;
    capture    = 1'b0;
    idx_inc    = 1'b0;
    commit     = 1'b0;
    pad_latch  = 1'b0;
    pad_clk    = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LATCH;
          load_cnt   = 1'b1;
          clr_scan   = 1'b1;
        end
      end
      LATCH: begin
        pad_latch = 1'b1;
        busy      = 1'b1;
        // The 8-bit counter only spans one half-period, so the latch pulse
        // runs it twice, tracked by second_half.
        if (cnt_zero) begin
          load_cnt = 1'b1;
          if (second_half) state_next = HIGH;
          else             set_half   = 1'b1;
        end
      end
      HIGH: begin
        busy = 1'b1;
        if (cnt_zero) begin
          capture    = 1'b1;
          load_cnt   = 1'b1;
          state_next = LOW;
        end
      end
      LOW: begin
        pad_clk = 1'b0;
        busy    = 1'b1;
        if (cnt_zero) begin
          load_cnt = 1'b1;
          if (idx == LAST_IDX) begin
            state_next = COMMIT;
          end else begin
            idx_inc    = 1'b1;
            state_next = HIGH;
          end
        end
      end
      COMMIT: begin
        done       = 1'b1;
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_meta    <= '1;
      data_sync    <= '1;
      cnt          <= '0;
      second_half  <= 1'b0;
      idx          <= '0;
      shift_p1     <= '0;
      shift_p2     <= '0;
      pad_state_p1 <= '0;
      pad_state_p2 <= '0;
    end else begin
      data_meta <= pad_data;
      data_sync <= data_meta;
      if (load_cnt)      cnt <= CNT_RELOAD;
      else if (!cnt_zero) cnt <= cnt - 8'd1;
      if (clr_scan) begin
        second_half <= 1'b0;
        idx         <= '0;
        shift_p1    <= '0;
        shift_p2    <= '0;
      end
      if (set_half) second_half <= 1'b1;
      if (idx_inc)  idx <= idx + 1'b1;
      // Shift regs start cleared, so only pressed (low) bits need setting.
      if (capture) begin
        if (!data_sync[0]) shift_p1 <= shift_p1 | bit_mask;
        if (!data_sync[1]) shift_p2 <= shift_p2 | bit_mask;
      end
      if (commit) begin
        pad_state_p1 <= shift_p1;
        pad_state_p2 <= shift_p2;
      end
    end
  end

endmodule

// File: tb/tb_pad_poller.sv
// Self-checking bench for pad_poller: default instance plus a
// PAD_BITS=12 / HALF_PERIOD=6 instance, each driven by a behavioural pad model.
module tb_pad_poller;

  localparam int HA = 4;
  localparam int PA = 16;
  localparam int HB = 6;
  localparam int PB = 12;

  logic        clk;
  logic        resetn;
  logic        start_a, start_b;
  logic        pad_latch_a, pad_clk_a, busy_a, done_a;
  logic        pad_latch_b, pad_clk_b, busy_b, done_b;
  logic [1:0]  pad_data_a, pad_data_b;
  logic [15:0] p1_a, p2_a, p1_b, p2_b;

  // pad button words (1 = pressed) and pad-side bit pointers
  logic [15:0] pa1, pa2, pb1, pb2;
  int          idx_a, idx_b;

  int tests, fails;

  int r_done_first, r_done_cnt, r_latch_first, r_latch_cnt;
  int r_clk_pulses, r_clk_low, r_bad_change;
  logic r_busy1, r_busy_done;

  pad_poller dut_a (
    .clk(clk), .resetn(resetn), .start(start_a),
    .pad_latch(pad_latch_a), .pad_clk(pad_clk_a), .pad_data(pad_data_a),
    .pad_state_p1(p1_a), .pad_state_p2(p2_a), .busy(busy_a), .done(done_a)
  );

  pad_poller #(.HALF_PERIOD(HB), .PAD_BITS(PB)) dut_b (
    .clk(clk), .resetn(resetn), .start(start_b),
    .pad_latch(pad_latch_b), .pad_clk(pad_clk_b), .pad_data(pad_data_b),
    .pad_state_p1(p1_b), .pad_state_p2(p2_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pad model: latch reloads bit 0, each rising pad clock advances one bit,
  // data is active-low and idles high once the word is exhausted.
  initial begin idx_a = 16; idx_b = 16; end
  always @(posedge pad_latch_a) idx_a = 0;
  always @(posedge pad_clk_a) if (!pad_latch_a) idx_a = idx_a + 1;
  always @(posedge pad_latch_b) idx_b = 0;
  always @(posedge pad_clk_b) if (!pad_latch_b) idx_b = idx_b + 1;
  always @* begin
    pad_data_a = (idx_a < 16) ? ~{pa2[idx_a[3:0]], pa1[idx_a[3:0]]} : 2'b11;
    pad_data_b = (idx_b < 16) ? ~{pb2[idx_b[3:0]], pb1[idx_b[3:0]]} : 2'b11;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    resetn  = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge (cycle 0); start is high for cycle 0 and for the
  // extra cycles x1/x2. Records timing observations over the window.
  task automatic run_scan_a(input int x1, input int x2, input int window);
    logic [15:0] prev1, prev2;
    logic pclk;
    r_done_first = -1; r_done_cnt = 0; r_latch_first = -1; r_latch_cnt = 0;
    r_clk_pulses = 0; r_clk_low = 0; r_bad_change = 0;
    r_busy1 = 1'b0; r_busy_done = 1'b1;
    prev1 = p1_a; prev2 = p2_a; pclk = pad_clk_a;
    start_a = 1'b1;
    for (int k = 1; k <= window; k++) begin
      @(negedge clk);
      start_a = (k == x1) || (k == x2);
      if (done_a) begin
        r_done_cnt++;
        if (r_done_first < 0) begin r_done_first = k; r_busy_done = busy_a; end
      end
      if (pad_latch_a) begin
        r_latch_cnt++;
        if (r_latch_first < 0) r_latch_first = k;
      end
      if (!pad_clk_a) begin
        r_clk_low++;
        if (pclk) r_clk_pulses++;
      end
      pclk = pad_clk_a;
      if (k == 1) r_busy1 = busy_a;
      if ((p1_a !== prev1 || p2_a !== prev2) && !(r_done_first >= 0 && k == r_done_first + 1))
        r_bad_change++;
      prev1 = p1_a; prev2 = p2_a;
    end
    start_a = 1'b0;
  endtask

  task automatic run_scan_b(input int window);
    r_done_first = -1; r_done_cnt = 0;
    start_b = 1'b1;
    for (int k = 1; k <= window; k++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (done_b) begin
        r_done_cnt++;
        if (r_done_first < 0) r_done_first = k;
      end
    end
  endtask

  typedef struct {
    logic [15:0] w1, w2, e1, e2;
  } vec_t;

  vec_t vecs[4];

  initial begin : main
    int exp_done_a, exp_done_b;
    int dq[$];
    logic [15:0] vq[$];
    logic [15:0] w1, w2, mask_b;

    vecs[0] = '{w1: 16'h1234, w2: 16'h8001, e1: 16'h1234, e2: 16'h8001};
    vecs[1] = '{w1: 16'h0000, w2: 16'hFFFF, e1: 16'h0000, e2: 16'hFFFF};
    vecs[2] = '{w1: 16'hFFFF, w2: 16'h0000, e1: 16'hFFFF, e2: 16'h0000};
    vecs[3] = '{w1: 16'hAAAA, w2: 16'h5555, e1: 16'hAAAA, e2: 16'h5555};

    tests = 0; fails = 0;
    exp_done_a = 1 + 2 * HA + 2 * HA * PA;
    exp_done_b = 1 + 2 * HB + 2 * HB * PB;
    mask_b = 16'((1 << PB) - 1);
    pa1 = '0; pa2 = '0; pb1 = '0; pb2 = '0;

    // Reset and idle
    do_reset();
    repeat (50) @(negedge clk);
    check("idle_latch", pad_latch_a, 1'b0);
    check("idle_clk",   pad_clk_a,   1'b1);
    check("idle_busy",  busy_a,      1'b0);
    check("idle_done",  done_a,      1'b0);
    check("idle_p1",    p1_a,        16'h0000);
    check("idle_p2",    p2_a,        16'h0000);

    // Table-driven scans with full timing checks
    for (int i = 0; i < 4; i++) begin
      pa1 = vecs[i].w1; pa2 = vecs[i].w2;
      run_scan_a(-1, -1, 160);
      check("tbl_done_cycle",  r_done_first,  exp_done_a);
      check("tbl_done_count",  r_done_cnt,    1);
      check("tbl_latch_first", r_latch_first, 1);
      check("tbl_latch_len",   r_latch_cnt,   2 * HA);
      check("tbl_clk_pulses",  r_clk_pulses,  PA);
      check("tbl_clk_low",     r_clk_low,     HA * PA);
      check("tbl_busy_c1",     r_busy1,       1'b1);
      check("tbl_busy_done",   r_busy_done,   1'b0);
      check("tbl_no_partial",  r_bad_change,  0);
      check("tbl_p1",          p1_a,          vecs[i].e1);
      check("tbl_p2",          p2_a,          vecs[i].e2);
      repeat (3) @(negedge clk);
    end

    // Start pulses during a scan (cycle 10 and at the done cycle) are ignored
    pa1 = 16'h1234; pa2 = 16'h8001;
    run_scan_a(10, exp_done_a, 220);
    check("ign_done_count", r_done_cnt,   1);
    check("ign_done_cycle", r_done_first, exp_done_a);
    check("ign_latch_len",  r_latch_cnt,  2 * HA);
    check("ign_busy_after", busy_a,       1'b0);

    // Randomized scans against the model on both instances
    for (int i = 0; i < 6; i++) begin
      w1 = 16'($urandom); w2 = 16'($urandom);
      pa1 = w1; pa2 = w2;
      run_scan_a(-1, -1, 150);
      check("rnd_a_done", r_done_first, exp_done_a);
      check("rnd_a_p1",   p1_a, w1);
      check("rnd_a_p2",   p2_a, w2);
      w1 = 16'($urandom); w2 = 16'($urandom);
      pb1 = w1; pb2 = w2;
      run_scan_b(180);
      check("rnd_b_done", r_done_first, exp_done_b);
      check("rnd_b_p1",   p1_b, w1 & mask_b);
      check("rnd_b_p2",   p2_b, w2 & mask_b);
    end

    // Parameterised instance with a fixed pattern
    pb1 = 16'h0ABC; pb2 = 16'hF00F;
    run_scan_b(200);
    check("b_done_cycle", r_done_first, 157);
    check("b_done_count", r_done_cnt,   1);
    check("b_p1",         p1_b,         16'h0ABC);
    check("b_p2",         p2_b,         16'h000F);

    // start held high: back-to-back scans, pad 1 changes after the first
    pa1 = 16'h0001; pa2 = 16'h0000;
    do_reset();
    vq.push_back(p1_a);
    start_a = 1'b1;
    for (int k = 1; k <= 500; k++) begin
      @(negedge clk);
      if (done_a) begin
        dq.push_back(k);
        pa1 = 16'h0002;
      end
      if (p1_a !== vq[$]) vq.push_back(p1_a);
    end
    start_a = 1'b0;
    repeat (200) @(negedge clk);
    check("held_done_count", dq.size(), 3);
    check("held_first_done", (dq.size() > 0) ? dq[0] : -1, exp_done_a);
    for (int i = 1; i < dq.size(); i++)
      check("held_done_gap", dq[i] - dq[i-1], exp_done_a + 1);
    check("held_p1_steps", vq.size(), 3);
    check("held_p1_step1", (vq.size() > 1) ? vq[1] : 16'hDEAD, 16'h0001);
    check("held_p1_step2", (vq.size() > 2) ? vq[2] : 16'hDEAD, 16'h0002);

    // Reset in the middle of a scan after committing all-ones
    pa1 = 16'hFFFF; pa2 = 16'hFFFF;
    run_scan_a(-1, -1, 150);
    check("pre_rst_p1", p1_a, 16'hFFFF);
    start_a = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    resetn = 1'b0;
    #1;
    check("rst_p1",    p1_a,        16'h0000);
    check("rst_p2",    p2_a,        16'h0000);
    check("rst_clk",   pad_clk_a,   1'b1);
    check("rst_latch", pad_latch_a, 1'b0);
    check("rst_busy",  busy_a,      1'b0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    r_done_cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done_a) r_done_cnt++;
    end
    check("rst_no_done", r_done_cnt, 0);
    check("rst_p1_hold", p1_a, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pad_poller.md
Name: pad_poller

Overview:
Autonomous SNES-style serial gamepad scanner for two pads. It replaces the CPU-bit-banged pad_ctrl/pad_read_data path. On a start pulse (wired to the VDP active_frame_ended strobe) it drives latch/clock to the pads and shifts in PAD_BITS per pad. It then presents debounce-free, active-high button words that the bus arbiter reads as MMIO. It sits between the pad pins and the pad_en read mux, in the vdp_clk domain.

Parameters:
HALF_PERIOD, 4, pad clock half-period in clk cycles; legal range 4..255; elaboration error outside range
PAD_BITS, 16, bits shifted per pad per scan; legal range 1..16

Ports:
clk  input  1  system clock (vdp_clk)
resetn  input  1  asynchronous active-low reset
start  input  1  scan request pulse; sampled only in IDLE
pad_latch  output  1  latch strobe to both pads, active-high
pad_clk  output  1  shared pad clock; idles high
pad_data  input  2  serial data, [0]=pad 1, [1]=pad 2; active-low, asynchronous to clk
pad_state_p1  output  16  pad 1 buttons, bit i = i-th shifted bit, 1=pressed; bits >= PAD_BITS read 0
pad_state_p2  output  16  pad 2, same format
busy  output  1  high from start acceptance until the done cycle (exclusive)
done  output  1  one-cycle pulse when pad_state_* update

Behaviour:
- Reset (async assert, sync release): pad_latch=0, pad_clk=1, pad_state_p1/p2=0, busy=0, done=0, FSM=IDLE, counters=0, shift regs=0, synchroniser flops=1.
- pad_data passes through a 2-flop synchroniser per bit. All sampling uses the synchronised value.
- FSM states: IDLE, LATCH, HIGH, LOW, COMMIT.
- IDLE: when start=1 on an edge (call this cycle 0), go to LATCH. busy=1 from cycle 1.
- LATCH: pad_latch=1 and pad_clk=1 for exactly 2*HALF_PERIOD cycles (cycles 1..2H). Then go to HIGH with bit index 0.
- HIGH: pad_latch=0, pad_clk=1 for HALF_PERIOD cycles.
  - On the last cycle of HIGH, capture the inverted synchronised pad_data[0] into shift reg p1 bit[index], and pad_data[1] into p2 bit[index].
  - Then go to LOW.
- LOW: pad_clk=0 for HALF_PERIOD cycles.
  - If index == PAD_BITS-1, go to COMMIT.
  - Otherwise, increment index and go to HIGH.
- COMMIT (one cycle): pad_state_p1/p2 are loaded from the shift regs, visible the following cycle. done=1 and busy=0 in this cycle. Return to IDLE next cycle.
- Timing: done asserts at cycle 1 + 2H + 2H*PAD_BITS. With defaults this is cycle 137. Consecutive scans are separated by at least one IDLE cycle.
- Output stability: pad_state_* are unchanged at all times except the cycle after COMMIT; they never show partial scans.
- start while busy (any non-IDLE state), including start coincident with COMMIT: ignored. No queuing.
- start held high continuously: a new scan begins on the first IDLE cycle after each COMMIT.
- Shift regs are cleared at the LATCH entry so unused bits read 0.
- resetn asserted mid-scan: immediate return to reset values. pad_state_* are cleared (the last committed value is not held), pad_clk returns high, and no done pulse is produced.
- Bit index counter width: clog2(PAD_BITS)+1. Half-period counter width: 8 bits, reloaded on every state entry.

Test Plan:
1. Reset then idle 50 cycles -> pad_latch=0, pad_clk=1, busy=0, done=0, pad_state_p1=pad_state_p2=16'h0000.
2. Pad models return active-low 16'h1234 (pad 1) and 16'h8001 (pad 2), LSB first; start pulse at cycle 0 -> pad_latch high cycles 1..8; 16 pad_clk low pulses of 4 cycles each; done at cycle 137; pad_state_p1=16'h1234 and pad_state_p2=16'h8001 from cycle 138.
3. Second start pulses at cycles 10 and 137 during scan from test 2 -> both ignored; exactly one done; next scan only on a later start.
4. start held high 500 cycles with a pad-1 model changing from 16'h0001 to 16'h0002 between scans -> done pulses 138 cycles apart; pad_state_p1 steps 0x0001 then 0x0002 with no intermediate values.
5. resetn asserted at cycle 60 of a scan that follows a committed 16'hFFFF -> same cycle: pad_state_p1=0, pad_clk=1, pad_latch=0, busy=0; no done pulse follows.
6. PAD_BITS=12, HALF_PERIOD=6, pad 1 presents 16'h0ABC -> done at cycle 1+12+144=157; pad_state_p1=16'h0ABC with bits [15:12]=0.
